// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU (1-cycle logic/arith, WIDTH-cycle shift-add MUL); valid_i/ready_o request in, valid_o/ready_i result out, result_o/zero_o/overflow_o registered result flags
module alu_mc #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WIDTH-1:0]  src1_i,
  input  logic [WIDTH-1:0]  src2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  result_o,
  output logic              zero_o,
  output logic              overflow_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_MUL  = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] OP_SLTU = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(4'b1100);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt, sum, diff, alu_res;
  logic [CW-1:0] cnt;
  logic add_ov, sub_ov, alu_ov, accept;
  always_comb begin
    sum     = src1_i + src2_i;
    diff    = src1_i - src2_i;
    add_ov  = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
    sub_ov  = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
    alu_ov  = ctrl_i == OP_ADD ? add_ov : ctrl_i == OP_SUB ? sub_ov : 1'b0;
    alu_res = ctrl_i == OP_AND  ? src1_i & src2_i :
              ctrl_i == OP_OR   ? src1_i | src2_i :
              ctrl_i == OP_ADD  ? sum :
              ctrl_i == OP_SUB  ? diff :
              ctrl_i == OP_SLT  ? WIDTH'($signed(src1_i) < $signed(src2_i)) :
              ctrl_i == OP_SLTU ? WIDTH'(src1_i < src2_i) :
              ctrl_i == OP_NOR  ? ~(src1_i | src2_i) : '0;
    ready_o = state == IDLE && !rst_i;
    accept  = valid_i && ready_o;
    acc_nxt = mplier[0] ? acc + mcand : acc;
    zero_o  = result_o == '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      result_o   <= '0;
      overflow_o <= 1'b0;
      valid_o    <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (ctrl_i == OP_MUL) begin
            mcand  <= src1_i;
            mplier <= src2_i;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end else begin
            result_o   <= alu_res;
            overflow_o <= alu_ov;
            valid_o    <= 1'b1;
            state      <= DONE;
          end
        end
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            result_o   <= acc_nxt;
            overflow_o <= 1'b0;
            valid_o    <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: if (ready_i) begin
          valid_o <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed scoreboard bench for alu_mc at WIDTH=32
module tb_alu_mc;
  logic clk = 1'b0, rst_i = 1'b1, valid_i = 1'b0, ready_i = 1'b0;
  logic ready_o, valid_o, zero_o, overflow_o;
  logic [31:0] src1_i = '0, src2_i = '0, result_o;
  logic [3:0] ctrl_i = '0;
  int checks = 0, errors = 0;
  logic [32:0] sb[$];
  alu_mc #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .src1_i(src1_i), .src2_i(src2_i), .ctrl_i(ctrl_i), .valid_o(valid_o),
    .ready_i(ready_i), .result_o(result_o), .zero_o(zero_o), .overflow_o(overflow_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    case (op)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: begin s = {a[31], a} + {b[31], b}; return {s[32] != s[31], s[31:0]}; end
      4'b0110: begin s = {a[31], a} - {b[31], b}; return {s[32] != s[31], s[31:0]}; end
      4'b0111: return {1'b0, 31'd0, $signed(a) < $signed(b)};
      4'b1000: return {1'b0, 31'd0, a < b};
      4'b1100: return {1'b0, ~(a | b)};
      4'b0011: return {1'b0, a * b};
      default: return 33'd0;
    endcase
  endfunction
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input int stall);
    int lat;
    logic [32:0] e;
    logic [31:0] held;
    chk({tag, ".ready_in"}, ready_o, 1);
    ctrl_i = op; src1_i = a; src2_i = b; valid_i = 1'b1;
    sb.push_back(model(op, a, b));
    @(negedge clk);
    valid_i = 1'b0; src1_i = $urandom; src2_i = $urandom; ctrl_i = 4'b0010;
    lat = 1;
    while (!valid_o && lat < 200) begin
      if (!ready_o) lat = lat; else chk({tag, ".ready_busy"}, ready_o, 0);
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    e = sb.size() > 0 ? sb.pop_front() : 33'h1_dead_beef;
    chk({tag, ".result"}, result_o, e[31:0]);
    chk({tag, ".overflow"}, overflow_o, e[32]);
    chk({tag, ".zero"}, zero_o, e[31:0] == 0);
    held = result_o;
    for (int i = 0; i < stall; i++) begin
      valid_i = 1'b1; src1_i = $urandom; src2_i = $urandom; ctrl_i = 4'b0001;
      @(negedge clk);
      chk({tag, ".stall_valid"}, valid_o, 1);
      chk({tag, ".stall_result"}, result_o, held);
      chk({tag, ".stall_ready"}, ready_o, 0);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk({tag, ".valid_drop"}, valid_o, 0);
    chk({tag, ".ready_back"}, ready_o, 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst.valid", valid_o, 0);
    chk("rst.result", result_o, 0);
    chk("rst.zero", zero_o, 1);
    chk("rst.overflow", overflow_o, 0);
    chk("rst.ready", ready_o, 0);
    rst_i = 1'b0;
    #1 chk("rst.ready_release", ready_o, 1);
    @(negedge clk);
    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1, 0);
    run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 1, 0);
    run_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 1, 0);
    run_op("sltu", 4'b1000, 32'hFFFF_FFFF, 32'd1, 1, 0);
    run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'd1, 1, 0);
    run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 0);
    run_op("or", 4'b0001, 32'hA000_0005, 32'h0500_0030, 1, 0);
    run_op("nor", 4'b1100, 32'h1234_5678, 32'h0F0F_0000, 1, 0);
    run_op("undef", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    run_op("mul", 4'b0011, 32'h0001_0000, 32'h0001_0001, 33, 0);
    run_op("mul_rand", 4'b0011, 32'h1234_5679, 32'h8765_4321, 33, 0);
    run_op("bp_add", 4'b0010, 32'd100, 32'hFFFF_FFF6, 1, 3);
    @(negedge clk);
    chk("bp.no_queued", valid_o, 0);
    ctrl_i = 4'b0011; src1_i = 32'd7; src2_i = 32'd9; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (9) @(negedge clk);
    chk("rstmul.busy", ready_o, 0);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("rstmul.valid", valid_o, 0);
    chk("rstmul.result", result_o, 0);
    chk("rstmul.zero", zero_o, 1);
    #1 chk("rstmul.ready", ready_o, 1);
    @(negedge clk);
    run_op("post_rst_add", 4'b0010, 32'd2, 32'd3, 1, 0);
    chk("sb.empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal range 8..64).
REQ-002 SHALL have parameter CTRL_W, default 4, meaning opcode width (fixed at 4).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  operation request present.
REQ-006 SHALL have port ready_o  output  1  block can accept a request this cycle.
REQ-007 SHALL have port src1_i  input  WIDTH  operand A.
REQ-008 SHALL have port src2_i  input  WIDTH  operand B.
REQ-009 SHALL have port ctrl_i  input  CTRL_W  opcode.
REQ-010 SHALL have port valid_o  output  1  result available.
REQ-011 SHALL have port ready_i  input  1  consumer takes result this cycle.
REQ-012 SHALL have port result_o  output  WIDTH  registered result.
REQ-013 SHALL have port zero_o  output  1  high when result_o == 0.
REQ-014 SHALL have port overflow_o  output  1  signed overflow of ADD/SUB; 0 for all other opcodes.

Function
REQ-015 SHALL decode ctrl_i as: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1000 SLTU (unsigned), 1100 NOR, 0011 MUL; any other code yields result 0, overflow 0, latency 1.
REQ-016 SHALL implement FSM states IDLE, MUL, DONE.
REQ-017 SHALL drive ready_o = 1 only in IDLE with rst_i low; accept = valid_i && ready_o.
REQ-018 SHALL capture src1_i, src2_i, ctrl_i on accept; later input changes SHALL NOT affect the operation.
REQ-019 SHALL, on accept of a non-MUL opcode, register the result and enter DONE next cycle (valid_o high 1 cycle after accept).
REQ-020 SHALL, on accept of MUL, enter MUL and run an unsigned shift-add, one multiplier bit per cycle, for exactly WIDTH cycles, then enter DONE (valid_o high WIDTH+1 cycles after accept).
REQ-021 SHALL make MUL result the low WIDTH bits of the product; high bits are discarded; overflow_o = 0.
REQ-022 SHALL wrap ADD/SUB modulo 2^WIDTH; overflow_o = 1 when operand signs match (ADD) or differ (SUB) and result sign differs from src1.
REQ-023 SHALL produce SLT/SLTU result as zero-extended 1 or 0.
REQ-024 SHALL, in DONE, hold valid_o = 1 and result_o/zero_o/overflow_o stable until ready_i is high; on ready_i high, return to IDLE next cycle (no accept in the DONE cycle itself).
REQ-025 SHALL ignore valid_i in MUL and DONE (ready_o = 0); no request queued.
REQ-026 SHALL derive zero_o combinationally from result_o at all times.

Reset
REQ-027 SHALL, with rst_i high at a clock edge, enter IDLE and set result_o = 0, overflow_o = 0, valid_o = 0 (hence zero_o = 1).
REQ-028 SHALL drive ready_o = 0 while rst_i is high and ready_o = 1 in the first cycle after rst_i falls.
REQ-029 SHALL abort any in-progress MUL or pending DONE result on reset; no valid_o for the aborted operation.
REQ-030 SHALL give rst_i priority over accept and ready_i in the same cycle.

Verification
REQ-031 SHALL verify (WIDTH=32) ADD 0x7FFFFFFF + 0x00000001 -> result_o 0x80000000, overflow_o 1, zero_o 0, valid_o 1 cycle after accept.
REQ-032 SHALL verify SUB 5 - 5 -> result_o 0, zero_o 1, overflow_o 0; SLT 0xFFFFFFFF vs 1 -> 1; SLTU 0xFFFFFFFF vs 1 -> 0.
REQ-033 SHALL verify MUL 0x00010000 * 0x00010001 -> result_o 0x00010000, valid_o exactly 33 cycles after accept, ready_o 0 throughout.
REQ-034 SHALL verify backpressure: ready_i held 0 for 3 cycles in DONE -> valid_o and result_o stable, concurrent valid_i with new operands ignored, ready_o 1 the cycle after ready_i = 1.
REQ-035 SHALL verify rst_i asserted at MUL cycle 10 -> next cycle IDLE, valid_o 0, result_o 0, zero_o 1; a following ADD 2 + 3 returns 5.
REQ-036 SHALL verify undefined opcode 1111 with src1 = src2 = 0xFFFFFFFF -> result_o 0, zero_o 1, overflow_o 0.
